// File: rtl/seq_mult_responder.sv
// rtl/seq_mult_responder.sv - sequential signed multiplier, strobe/ack responder
// Operands are captured independently; a radix-2 shift-add runs over magnitudes.
module seq_mult_responder #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     num1,
  input  logic [WIDTH-1:0]     num2,
  input  logic                 num1_stb,
  input  logic                 num2_stb,
  output logic                 num1_ack,
  output logic                 num2_ack,
  output logic [2*WIDTH-1:0]   result,
  output logic                 result_ack
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, CAPT, MUL, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic               num1_ack_q, num1_ack_d, num2_ack_q, num2_ack_d;
  logic               cap1_q, cap1_d, cap2_q, cap2_d;
  logic [WIDTH-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [WIDTH:0]     a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, result_q, result_d;
  logic               result_ack_q, result_ack_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               cap_ok, take1, take2;
  logic [WIDTH:0]     ext1, ext2;

  always_comb begin
    state_d      = state_q;
    num1_ack_d   = num1_ack_q;
    num2_ack_d   = num2_ack_q;
    cap1_d       = cap1_q;
    cap2_d       = cap2_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    a_d          = a_q;
    b_d          = b_q;
    sign_d       = sign_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    result_ack_d = result_ack_q;

    cap_ok = (state_q == IDLE) || (state_q == CAPT) || (state_q == DONE);
    take1  = num1_stb && !num1_ack_q && !cap1_q && cap_ok;
    take2  = num2_stb && !num2_ack_q && !cap2_q && cap_ok;
    ext1   = {op1_q[WIDTH-1], op1_q};
    ext2   = {op2_q[WIDTH-1], op2_q};

    // Ack release tracks the strobe only, regardless of compute state.
    num1_ack_d = num1_ack_q ? num1_stb : take1;
    num2_ack_d = num2_ack_q ? num2_stb : take2;
    if (take1) begin
      op1_d  = num1;
      cap1_d = 1'b1;
    end
    if (take2) begin
      op2_d  = num2;
      cap2_d = 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (take1 || take2) begin
          result_ack_d = 1'b0;
          state_d      = CAPT;
        end
      end
      CAPT: begin
        if (cap1_q && cap2_q) begin
          // WIDTH+1-bit magnitudes keep the most negative operand exact.
          a_d     = ext1[WIDTH] ? -ext1 : ext1;
          b_d     = ext2[WIDTH] ? -ext2 : ext2;
          sign_d  = (op1_q[WIDTH-1] ^ op2_q[WIDTH-1]) && (op1_q != '0) && (op2_q != '0);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (b_q[0]) begin
          acc_d = acc_q + ({{(WIDTH-1){1'b0}}, a_q} << cnt_q);
        end
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d     = sign_q ? -acc_q : acc_q;
        result_ack_d = 1'b1;
        cap1_d       = 1'b0;
        cap2_d       = 1'b0;
        state_d      = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      num1_ack_q   <= 1'b0;
      num2_ack_q   <= 1'b0;
      cap1_q       <= 1'b0;
      cap2_q       <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sign_q       <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      result_ack_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      num1_ack_q   <= num1_ack_d;
      num2_ack_q   <= num2_ack_d;
      cap1_q       <= cap1_d;
      cap2_q       <= cap2_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sign_q       <= sign_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      result_ack_q <= result_ack_d;
    end
  end

  assign num1_ack   = num1_ack_q;
  assign num2_ack   = num2_ack_q;
  assign result     = result_q;
  assign result_ack = result_ack_q;

endmodule

// File: doc/seq_mult_responder.md
# seq_mult_responder

Sequential signed multiplier acting as the responder side of the team's two-operand strobe/acknowledge arithmetic handshake. The matrix multiply controller, or any other initiator, presents `num1`/`num2` with `num1_stb`/`num2_stb` and waits for both acks. It then drops its strobes and waits for `result_ack`. The block captures each operand independently, runs a radix-2 shift-add over magnitudes, applies the sign, and holds the 32-bit product with `result_ack` high until the next operation is captured.

## Interface
- `WIDTH`, default 16: operand width in bits (signed, two's complement). The product is 2*WIDTH bits.
- `clk`  in  1: sole clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `num1`  in  WIDTH: signed multiplicand; sampled only on its capture edge.
- `num2`  in  WIDTH: signed multiplier; sampled only on its capture edge.
- `num1_stb`  in  1: initiator asserts while `num1` is valid; held until `num1_ack` is seen.
- `num2_stb`  in  1: same as `num1_stb`, for `num2`.
- `num1_ack`  out  1: high from the cycle after `num1` capture until `num1_stb` is sampled low.
- `num2_ack`  out  1: same as `num1_ack`, for `num2`.
- `result`  out  2*WIDTH: signed product; stable while `result_ack` is high.
- `result_ack`  out  1: product valid level; held high until the next operand capture.

## Operation
- Reset values: `num1_ack`=0, `num2_ack`=0, `result_ack`=0, `result`=0, state=IDLE, both captured flags=0.
- States:
  - IDLE: no result held yet.
  - CAPT: one or both operands captured; waiting for the second.
  - MUL: WIDTH iterations.
  - FIX: sign application.
  - DONE: result held.
- Capture rule for operand n:
  - Capture occurs on an edge where `numn_stb`=1, `numn_ack`=0, the operand is not yet captured, and state ∈ {IDLE, CAPT, DONE}.
  - The block latches the operand, sets the captured flag, and asserts `numn_ack` on that edge.
- The first capture from IDLE or DONE clears `result_ack` on the same edge and moves to CAPT.
- Strobes may arrive on the same edge or on different edges, in either order.
- Once both operands are captured, the next state is MUL:
  - Load |num1| and |num2| as WIDTH+1-bit magnitudes, so -2^(WIDTH-1) is exact.
  - Record sign = num1[MSB] XOR num2[MSB].
  - Clear the accumulator and iteration counter.
- MUL, each cycle:
  - If the multiplier LSB is 1, add the multiplicand, shifted by the iteration count, to a 2*WIDTH accumulator.
  - Shift the multiplier right and increment the counter.
  - After WIDTH iterations go to FIX.
- FIX: `result` = sign ? -acc : acc, truncated to 2*WIDTH bits. Then go to DONE with `result_ack`=1 and both captured flags cleared.
- Ack release is independent of the compute state:
  - `numn_ack` drops on the first edge where `numn_stb` is sampled 0.
  - A strobe held high after its ack never causes a second capture.
- A new strobe arriving during MUL/FIX (ack low, stb high) is not captured; the ack stays low until DONE, then capture follows the normal rule.
- Reset mid-operation: all outputs return to their reset values on that edge, and the in-flight product is discarded.
- Product range: (-2^(WIDTH-1))² = 2^(2*WIDTH-2) fits in 2*WIDTH signed; no overflow case exists.

## Timing
- Edge E = the edge capturing the second operand. Acks are visible in cycle E+1.
- MUL occupies E+1 through E+WIDTH. FIX is at E+WIDTH+1.
- `result_ack` and `result` are valid from edge E+WIDTH+2: 18 cycles for WIDTH=16.
- `result_ack` stays high indefinitely until the next capture edge, which clears it.
- Back-to-back operation: the initiator drops its strobes one cycle after seeing the acks and can re-strobe after the acks fall. Throughput is one product per WIDTH+2 cycles plus handshake cycles.
- Outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Basic product: `num1`=3, `num2`=-5, both strobes at cycle 0 → acks at cycle 1; `result`=-15 (0xFFFFFFF1) with `result_ack`=1 at cycle 18.
- Corner operands: -32768 × -32768 → 0x40000000. -32768 × 1 → 0xFFFF8000. 0 × -1 → 0, with sign forced clear.
- Staggered strobes: `num2_stb` 5 cycles after `num1_stb` → `num1_ack` high alone for 5 cycles, MUL starts only after `num2` capture, and `result_ack` rises 18 cycles after the `num2` capture.
- Held strobe and early re-strobe:
  - Strobes held high for 30 cycles after ack → exactly one capture, acks stay high, no re-capture after DONE.
  - A new strobe during MUL → no ack until DONE.
- Back-to-back: 7×6 then 100×-200 → 42, then `result_ack` falls on the second capture edge, then -20000.
- Reset mid-operation: `rst` at cycle 8 of MUL → all outputs 0 next cycle. A new 2×2 after reset yields 4 with correct latency.
